// File: rtl/whirlpool_wcipher_gamma_folded.sv
// Folded Whirlpool Gamma layer: LANES shared S-boxes sweep the 64-byte state
// one slice per cycle, with valid/ready handshakes on both sides.
module whirlpool_wcipher_gamma_folded #(
    parameter int LANES = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_abort,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [0:511] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [0:511] o_data,
    output logic         o_busy
);

    localparam int NSTEP = 64 / LANES;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    localparam logic [7:0] SBOX [256] = '{
        8'h18, 8'h23, 8'hC6, 8'hE8, 8'h87, 8'hB8, 8'h01, 8'h4F, 8'h36, 8'hA6, 8'hD2, 8'hF5, 8'h79, 8'h6F, 8'h91, 8'h52,
        8'h60, 8'hBC, 8'h9B, 8'h8E, 8'hA3, 8'h0C, 8'h7B, 8'h35, 8'h1D, 8'hE0, 8'hD7, 8'hC2, 8'h2E, 8'h4B, 8'hFE, 8'h57,
        8'h15, 8'h77, 8'h37, 8'hE5, 8'h9F, 8'hF0, 8'h4A, 8'hDA, 8'h58, 8'hC9, 8'h29, 8'h0A, 8'hB1, 8'hA0, 8'h6B, 8'h85,
        8'hBD, 8'h5D, 8'h10, 8'hF4, 8'hCB, 8'h3E, 8'h05, 8'h67, 8'hE4, 8'h27, 8'h41, 8'h8B, 8'hA7, 8'h7D, 8'h95, 8'hD8,
        8'hFB, 8'hEE, 8'h7C, 8'h66, 8'hDD, 8'h17, 8'h47, 8'h9E, 8'hCA, 8'h2D, 8'hBF, 8'h07, 8'hAD, 8'h5A, 8'h83, 8'h33,
        8'h63, 8'h02, 8'hAA, 8'h71, 8'hC8, 8'h19, 8'h49, 8'hD9, 8'hF2, 8'hE3, 8'h5B, 8'h88, 8'h9A, 8'h26, 8'h32, 8'hB0,
        8'hE9, 8'h0F, 8'hD5, 8'h80, 8'hBE, 8'hCD, 8'h34, 8'h48, 8'hFF, 8'h7A, 8'h90, 8'h5F, 8'h20, 8'h68, 8'h1A, 8'hAE,
        8'hB4, 8'h54, 8'h93, 8'h22, 8'h64, 8'hF1, 8'h73, 8'h12, 8'h40, 8'h08, 8'hC3, 8'hEC, 8'hDB, 8'hA1, 8'h8D, 8'h3D,
        8'h97, 8'h00, 8'hCF, 8'h2B, 8'h76, 8'h82, 8'hD6, 8'h1B, 8'hB5, 8'hAF, 8'h6A, 8'h50, 8'h45, 8'hF3, 8'h30, 8'hEF,
        8'h3F, 8'h55, 8'hA2, 8'hEA, 8'h65, 8'hBA, 8'h2F, 8'hC0, 8'hDE, 8'h1C, 8'hFD, 8'h4D, 8'h92, 8'h75, 8'h06, 8'h8A,
        8'hB2, 8'hE6, 8'h0E, 8'h1F, 8'h62, 8'hD4, 8'hA8, 8'h96, 8'hF9, 8'hC5, 8'h25, 8'h59, 8'h84, 8'h72, 8'h39, 8'h4C,
        8'h5E, 8'h78, 8'h38, 8'h8C, 8'hD1, 8'hA5, 8'hE2, 8'h61, 8'hB3, 8'h21, 8'h9C, 8'h1E, 8'h43, 8'hC7, 8'hFC, 8'h04,
        8'h51, 8'h99, 8'h6D, 8'h0D, 8'hFA, 8'hDF, 8'h7E, 8'h24, 8'h3B, 8'hAB, 8'hCE, 8'h11, 8'h8F, 8'h4E, 8'hB7, 8'hEB,
        8'h3C, 8'h81, 8'h94, 8'hF7, 8'hB9, 8'h13, 8'h2C, 8'hD3, 8'hE7, 8'h6E, 8'hC4, 8'h03, 8'h56, 8'h44, 8'h7F, 8'hA9,
        8'h2A, 8'hBB, 8'hC1, 8'h53, 8'hDC, 8'h0B, 8'h9D, 8'h6C, 8'h31, 8'h74, 8'hF6, 8'h46, 8'hAC, 8'h89, 8'h14, 8'hE1,
        8'h16, 8'h3A, 8'h69, 8'h09, 8'h70, 8'hB6, 8'hD0, 8'hED, 8'hCC, 8'h42, 8'h98, 8'hA4, 8'h28, 8'h5C, 8'hF8, 8'h86
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[x];
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [0:511]    work;
    logic [0:511]    work_gamma;
    logic            accept;
    logic            last;
    int              base;

    assign accept = (state == IDLE) && i_valid && !i_abort;
    assign last   = (cnt == CW'(NSTEP - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (i_abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (i_valid) state_next = RUN;
                RUN:     if (last)    state_next = DONE;
                DONE:    if (i_ready) state_next = IDLE;
                default:              state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        o_ready = (state == IDLE);
        o_valid = (state == DONE);
        o_busy  = (state != IDLE);
    end

    // Slice counter restarts on every accept so a state always sweeps from byte 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_abort || accept) begin
            cnt <= '0;
        end else if (state == RUN) begin
            cnt <= last ? '0 : cnt + CW'(1);
        end
    end

    // Only the current slice is substituted; all other bytes pass through.
    always_comb begin
        base       = (NSTEP == 1) ? 0 : int'(cnt) * LANES;
        work_gamma = work;
        for (int j = 0; j < LANES; j++) begin
            work_gamma[(base + j) * 8 +: 8] = sbox(work[(base + j) * 8 +: 8]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            work <= '0;
        end else if (accept) begin
            work <= i_data;
        end else if (state == RUN && !i_abort) begin
            work <= work_gamma;
        end
    end

    assign o_data = work;

endmodule

// File: tb/tb_whirlpool_wcipher_gamma_folded.sv
// Bench for the folded Gamma layer: directed handshake/abort/reset cases plus a
// randomized sweep over LANES=8,1,4,64 against a mini-box Gamma model.
module tb_whirlpool_wcipher_gamma_folded;

    localparam int NI = 4;

    // Whirlpool S-box built from its 4-bit E, E^-1 and R mini-boxes.
    localparam logic [3:0] E_TAB  [16] = '{4'h1, 4'hB, 4'h9, 4'hC, 4'hD, 4'h6, 4'hF, 4'h3,
                                           4'hE, 4'h8, 4'h7, 4'h4, 4'hA, 4'h2, 4'h5, 4'h0};
    localparam logic [3:0] EI_TAB [16] = '{4'hF, 4'h0, 4'hD, 4'h7, 4'hB, 4'hE, 4'h5, 4'hA,
                                           4'h9, 4'h2, 4'hC, 4'h1, 4'h3, 4'h4, 4'h8, 4'h6};
    localparam logic [3:0] R_TAB  [16] = '{4'h7, 4'hC, 4'hB, 4'hD, 4'hE, 4'h4, 4'h9, 4'hF,
                                           4'h6, 4'h3, 4'h8, 4'hA, 4'h2, 4'h5, 4'h1, 4'h0};
    localparam logic [7:0] VEC_OUT [16] = '{8'h18, 8'h23, 8'hC6, 8'hE8, 8'h87, 8'hB8, 8'h01, 8'h4F,
                                            8'h36, 8'hA6, 8'hD2, 8'hF5, 8'h79, 8'h6F, 8'h91, 8'h52};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         abort;
    logic         rdy;
    logic [0:511] din;
    logic         vin   [NI];
    logic         ordy  [NI];
    logic         ovld  [NI];
    logic         obusy [NI];
    logic [0:511] dout  [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        whirlpool_wcipher_gamma_folded #(
            .LANES(g == 0 ? 8 : g == 1 ? 1 : g == 2 ? 4 : 64)
        ) u_dut (
            .i_clk   (clk),
            .i_rst_n (rst_n),
            .i_abort (abort),
            .i_valid (vin[g]),
            .o_ready (ordy[g]),
            .i_data  (din),
            .o_valid (ovld[g]),
            .i_ready (rdy),
            .o_data  (dout[g]),
            .o_busy  (obusy[g])
        );
    end

    function automatic int nstep(input int idx);
        case (idx)
            0:       return 8;
            1:       return 64;
            2:       return 16;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] sb_ref(input logic [7:0] x);
        logic [3:0] a, b, r;
        a = E_TAB[x[7:4]];
        b = EI_TAB[x[3:0]];
        r = R_TAB[a ^ b];
        return {E_TAB[a ^ r], EI_TAB[b ^ r]};
    endfunction

    // First nbytes bytes substituted, the rest untouched.
    function automatic logic [0:511] partial_ref(input logic [0:511] d, input int nbytes);
        logic [0:511] r;
        r = d;
        for (int k = 0; k < nbytes; k++) r[8*k +: 8] = sb_ref(d[8*k +: 8]);
        return r;
    endfunction

    function automatic logic [0:511] gamma_ref(input logic [0:511] d);
        return partial_ref(d, 64);
    endfunction

    function automatic logic [0:511] rnd512();
        logic [0:511] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [0:511] obs, input logic [0:511] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input logic [0:511] d);
        din      = d;
        vin[idx] = 1'b1;
        tick();
        vin[idx] = 1'b0;
    endtask

    task automatic wait_valid(input int idx, output int lat);
        lat = 0;
        while (ovld[idx] !== 1'b1 && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_txn(input int idx, input logic [0:511] d, input string tag);
        int lat;
        send(idx, d);
        wait_valid(idx, lat);
        chk({tag, "_lat"}, lat, nstep(idx));
        chk({tag, "_data"}, dout[idx], gamma_ref(d));
        tick();
        chk({tag, "_vld_clr"}, ovld[idx], 1'b0);
        chk({tag, "_rdy"}, ordy[idx], 1'b1);
    endtask

    initial begin
        logic [0:511] d;
        logic [0:511] e;
        int           lat;

        rst_n = 1'b0;
        abort = 1'b0;
        rdy   = 1'b1;
        din   = '0;
        for (int i = 0; i < NI; i++) vin[i] = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_vld", ovld[0], 1'b0);
        chk("rst_busy", obusy[0], 1'b0);
        chk("rst_data", dout[0], '0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) chk("rst_rdy", ordy[i], 1'b1);

        // all-zero state -> all 0x18
        send(0, '0);
        chk("run_busy", obusy[0], 1'b1);
        chk("run_rdy", ordy[0], 1'b0);
        wait_valid(0, lat);
        chk("zero_lat", lat, 8);
        chk("zero_data", dout[0], {64{8'h18}});
        tick();
        chk("zero_vld_clr", ovld[0], 1'b0);

        // byte k = k for k<16, 0xFF elsewhere
        d = {64{8'hFF}};
        e = {64{8'h86}};
        for (int k = 0; k < 16; k++) begin
            d[8*k +: 8] = 8'(k);
            e[8*k +: 8] = VEC_OUT[k];
        end
        send(0, d);
        wait_valid(0, lat);
        chk("vec_lat", lat, 8);
        chk("vec_data", dout[0], e);
        tick();

        // backpressure with ignored i_valid pulses
        rdy = 1'b0;
        d   = rnd512();
        send(0, d);
        wait_valid(0, lat);
        chk("bp_lat", lat, 8);
        for (int i = 0; i < 5; i++) begin
            vin[0] = 1'b1;
            din    = rnd512();
            tick();
            chk("bp_vld", ovld[0], 1'b1);
            chk("bp_data", dout[0], gamma_ref(d));
            chk("bp_rdy", ordy[0], 1'b0);
        end
        vin[0] = 1'b0;
        rdy    = 1'b1;
        tick();
        chk("bp_vld_clr", ovld[0], 1'b0);
        chk("bp_rdy_back", ordy[0], 1'b1);
        chk("bp_busy_clr", obusy[0], 1'b0);

        // abort with three slices done; register keeps the partial result
        d = rnd512();
        send(0, d);
        tick();
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_vld", ovld[0], 1'b0);
        chk("abort_rdy", ordy[0], 1'b1);
        chk("abort_busy", obusy[0], 1'b0);
        chk("abort_hold", dout[0], partial_ref(d, 24));

        // abort alongside i_valid in IDLE must not accept
        vin[0] = 1'b1;
        abort  = 1'b1;
        din    = rnd512();
        tick();
        vin[0] = 1'b0;
        abort  = 1'b0;
        chk("abort_idle_rdy", ordy[0], 1'b1);
        chk("abort_idle_busy", obusy[0], 1'b0);

        send(0, {64{8'h01}});
        wait_valid(0, lat);
        chk("ones_lat", lat, 8);
        chk("ones_data", dout[0], {64{8'h23}});
        tick();

        // asynchronous reset between edges mid-RUN
        send(0, rnd512());
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", ovld[0], 1'b0);
        chk("arst_data", dout[0], '0);
        chk("arst_busy", obusy[0], 1'b0);
        rst_n = 1'b1;
        tick();
        check_txn(0, rnd512(), "post_rst");

        // randomized sweep across lane counts
        for (int n = 0; n < 20; n++) check_txn(0, rnd512(), "rand_l8");
        for (int n = 0; n < 200; n++) check_txn(1, rnd512(), "rand_l1");
        for (int n = 0; n < 200; n++) check_txn(2, rnd512(), "rand_l4");
        for (int n = 0; n < 200; n++) check_txn(3, rnd512(), "rand_l64");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
